// File: rtl/defines_pkg.sv
// rtl/defines_pkg.sv - shared FSM state types for the multi-bank frame buffer
// Purpose: write/read FSM state enums used by pingpong_buff_ctrl.
package defines_pkg;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

endpackage

// File: rtl/buff_mem_dp.sv
// rtl/buff_mem_dp.sv - simple dual-port frame RAM with registered read
// Purpose: one write port and one read port over NWORDS words.
// Ports: clk, rst (sync, active-high, clears only the read register),
//        we_i/waddr_i/wdata_i write port, re_i/raddr_i read request,
//        rdata_o read data one cycle after re_i (held when re_i is low).
module buff_mem_dp #(
    parameter int WIDTH  = 16,
    parameter int NWORDS = 128,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [NWORDS];
    logic [WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_buff_ctrl.sv
// rtl/pingpong_buff_ctrl.sv - NBANK-way frame buffer controller (generalised ping-pong)
// Purpose: producer fills whole DEPTH-word frames into free banks, consumer
//          drains committed banks oldest-first; both sides run concurrently.
// Ports: clk, rst (sync, active-high)
//        wr_start/wr_valid/wr_data in, wr_busy out  - frame fill side
//        rd_start in, rd_busy/rd_data/rd_valid/rd_last out - frame drain side
//        bank_cnt out - committed banks (a bank being drained still counts)
//        err_ovf/err_udf out, clr_err in - sticky request errors
module pingpong_buff_ctrl
    import defines_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int NBANK = 2,
    parameter int AW    = $clog2(NBANK*DEPTH),
    parameter int CW    = $clog2(NBANK+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_start,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_busy,
    input  logic             rd_start,
    output logic             rd_busy,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_last,
    output logic [CW-1:0]    bank_cnt,
    output logic             err_ovf,
    output logic             err_udf,
    input  logic             clr_err
);

    localparam int              CNTW      = $clog2(DEPTH);
    localparam logic [AW-1:0]   STEP      = AW'(DEPTH);
    localparam logic [AW-1:0]   LAST_BASE = AW'((NBANK-1)*DEPTH);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DEPTH-1);
    localparam logic [CW-1:0]   FULL      = CW'(NBANK);

    wr_state_t       wr_state_q, wr_state_d;
    rd_state_t       rd_state_q, rd_state_d;
    logic [CNTW-1:0] wr_cntr_q, wr_cntr_d, rd_cntr_q, rd_cntr_d;
    logic [AW-1:0]   wr_base_q, wr_base_d, rd_base_q, rd_base_d;
    logic [CW-1:0]   bank_cnt_q, bank_cnt_d;
    logic            err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
    logic            rd_valid_q, rd_last_q;

    logic            wr_accept, wr_reject, wr_commit;
    logic            rd_accept, rd_reject, rd_release;
    logic            mem_we, mem_re;
    logic [AW-1:0]   mem_waddr, mem_raddr;

    // Bases step by DEPTH and wrap after the last bank, so no multiplier.
    function automatic logic [AW-1:0] next_base(input logic [AW-1:0] base);
        return (base == LAST_BASE) ? '0 : base + STEP;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_cntr_q  <= '0;
            rd_cntr_q  <= '0;
            wr_base_q  <= '0;
            rd_base_q  <= '0;
            bank_cnt_q <= '0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_cntr_q  <= wr_cntr_d;
            rd_cntr_q  <= rd_cntr_d;
            wr_base_q  <= wr_base_d;
            rd_base_q  <= rd_base_d;
            bank_cnt_q <= bank_cnt_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
            rd_valid_q <= mem_re;     // matches the RAM's one-cycle read latency
            rd_last_q  <= rd_release;
        end
    end

    // Request decoding happens only in idle; requests during a frame are ignored.
    assign wr_accept  = (wr_state_q == W_IDLE) && wr_start && (bank_cnt_q != FULL);
    assign wr_reject  = (wr_state_q == W_IDLE) && wr_start && (bank_cnt_q == FULL);
    assign wr_commit  = mem_we && (wr_cntr_q == CNT_LAST);
    assign rd_accept  = (rd_state_q == R_IDLE) && rd_start && (bank_cnt_q != '0);
    assign rd_reject  = (rd_state_q == R_IDLE) && rd_start && (bank_cnt_q == '0);
    assign rd_release = mem_re && (rd_cntr_q == CNT_LAST);

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        wr_cntr_d  = wr_cntr_q;
        rd_cntr_d  = rd_cntr_q;
        wr_base_d  = wr_base_q;
        rd_base_d  = rd_base_q;
        bank_cnt_d = bank_cnt_q;

        case (wr_state_q)
            W_IDLE:  if (wr_accept) wr_state_d = W_FILL;
            W_FILL:  if (wr_commit) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
        case (rd_state_q)
            R_IDLE:  if (rd_accept)  rd_state_d = R_DRAIN;
            R_DRAIN: if (rd_release) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase

        if (wr_accept)   wr_cntr_d = '0;
        else if (mem_we) wr_cntr_d = wr_cntr_q + 1'b1;
        if (rd_accept)   rd_cntr_d = '0;
        else if (mem_re) rd_cntr_d = rd_cntr_q + 1'b1;

        if (wr_commit)  wr_base_d = next_base(wr_base_q);
        if (rd_release) rd_base_d = next_base(rd_base_q);

        // Simultaneous commit and release cancel out.
        case ({wr_commit, rd_release})
            2'b10:   bank_cnt_d = bank_cnt_q + 1'b1;
            2'b01:   bank_cnt_d = bank_cnt_q - 1'b1;
            default: bank_cnt_d = bank_cnt_q;
        endcase

        // A new error outranks a clear in the same cycle.
        err_ovf_d = wr_reject | (err_ovf_q & ~clr_err);
        err_udf_d = rd_reject | (err_udf_q & ~clr_err);
    end

    always_comb begin
        wr_busy   = (wr_state_q == W_FILL);
        rd_busy   = (rd_state_q == R_DRAIN);
        mem_we    = wr_busy && wr_valid;
        mem_re    = rd_busy;
        mem_waddr = wr_base_q + {{(AW-CNTW){1'b0}}, wr_cntr_q};
        mem_raddr = rd_base_q + {{(AW-CNTW){1'b0}}, rd_cntr_q};
    end

    buff_mem_dp #(
        .WIDTH  (WIDTH),
        .NWORDS (NBANK*DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (wr_data),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign bank_cnt = bank_cnt_q;
    assign err_ovf  = err_ovf_q;
    assign err_udf  = err_udf_q;

endmodule

// File: doc/pingpong_buff_ctrl.md
# pingpong_buff_ctrl

- Parametrised multi-bank (ping-pong generalised to NBANK) frame buffer controller.
- A producer fills whole frames of DEPTH words into free banks while a consumer drains completed banks in FIFO order. Write and read run concurrently.
- Adds occupancy tracking, start/busy handshakes, last-word marking and sticky overflow/underflow errors.
- Sits between a sample-producing stage and a downstream processing stage in the datapath.

## Interface
- WIDTH, 16, data word width
- DEPTH, 64, words per frame (per bank), ≥2
- NBANK, 2, number of banks, ≥2
- AW, $clog2(NBANK*DEPTH), memory address width (derived)
- CW, $clog2(NBANK+1), bank-count width (derived)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_start  in  1  request to begin filling a new frame
- wr_valid  in  1  wr_data valid this cycle
- wr_data  in  WIDTH  write word
- wr_busy  out  1  frame fill in progress
- rd_start  in  1  request to drain the oldest full bank
- rd_busy  out  1  drain in progress
- rd_data  out  WIDTH  read word
- rd_valid  out  1  rd_data valid
- rd_last  out  1  final word of frame, coincident with rd_valid
- bank_cnt  out  CW  number of committed (full) banks
- err_ovf  out  1  sticky: wr_start with no free bank
- err_udf  out  1  sticky: rd_start with bank_cnt==0
- clr_err  in  1  clears both sticky errors

## Operation
- **Write FSM W_IDLE/W_FILL.**
  - In W_IDLE, wr_start with bank_cnt<NBANK goes to W_FILL: wr_cntr←0, base←wr_base.
  - wr_start with bank_cnt==NBANK sets err_ovf and stays in W_IDLE.
- **In W_FILL:**
  - Each wr_valid writes mem[base+wr_cntr], then wr_cntr++.
  - wr_valid on wr_cntr==DEPTH-1 commits the frame: bank_cnt++, wr_base advances by DEPTH (wraps to 0 after bank NBANK-1), return to W_IDLE.
  - Gaps in wr_valid are allowed.
  - wr_start while in W_FILL is ignored. wr_valid while in W_IDLE is ignored.
- **Read FSM R_IDLE/R_DRAIN.**
  - In R_IDLE, rd_start with bank_cnt>0 goes to R_DRAIN: rd_cntr←0.
  - rd_start with bank_cnt==0 sets err_udf.
- **In R_DRAIN:**
  - One read address (rd_base+rd_cntr) is issued every cycle, with no backpressure.
  - On issuing rd_cntr==DEPTH-1 the bank is released: bank_cnt--, rd_base advances with wrap, return to R_IDLE.
  - rd_start while in R_DRAIN is ignored.
- A bank under drain stays counted until released, so the writer can never overwrite unread data.
- Commit and release in the same cycle: bank_cnt unchanged.
- Error set and clr_err in the same cycle: the error stays set.
- Address arithmetic is base+counter with no multiplier. Bases are registers stepped by DEPTH.
- Reset mid-frame:
  - The partial frame is abandoned and both FSMs go to idle.
  - Bases and counters return to 0.
  - Memory contents are not cleared.

## Timing
- Reset values: wr_busy, rd_busy, rd_valid, rd_last, err_ovf, err_udf = 0; bank_cnt = 0; rd_data = 0.
- **Write path:**
  - wr_start accepted at cycle t: wr_busy=1 from t+1.
  - The first wr_valid counted is at t+1.
  - Final write at cycle c: bank_cnt increments at c+1; wr_busy=0 at c+1.
  - A new wr_start is accepted at c+1.
- **Read path:**
  - rd_start accepted at t: rd_busy=1 for t+1..t+DEPTH.
  - Addresses are issued at t+1..t+DEPTH; read latency is 1 cycle.
  - rd_valid=1 at t+2..t+DEPTH+1; rd_last at t+DEPTH+1.
  - bank_cnt decrements at t+DEPTH+1.
  - The earliest next rd_start is at t+DEPTH+1, giving a one-cycle gap between frames.
- A commit at cycle c is not visible to rd_start until c+1. rd_start at c with bank_cnt==0 flags err_udf.
- Errors set one cycle after the offending request. clr_err takes effect the next cycle.

## Structure
- defines_pkg: wr_state_t {W_IDLE, W_FILL} and rd_state_t {R_IDLE, R_DRAIN} enums.
- Sub-module buff_mem_dp:
  - Simple dual-port RAM, WIDTH × NBANK*DEPTH.
  - Synchronous write, registered synchronous read (1-cycle), read data register reset to 0.
- Controller body: two FSMs, two counters, two base registers, bank_cnt up/down counter, error flags.

## Test plan
All scenarios use WIDTH=16, DEPTH=4, NBANK=2.
1. Write 0x10..0x13, then rd_start → rd_data 0x10,0x11,0x12,0x13 on consecutive cycles; rd_last with 0x13; bank_cnt 1→0.
2. Fill two frames (0xA0.., 0xB0..), then a third wr_start → err_ovf=1, wr_busy stays 0; drain returns the A frame then the B frame in order.
3. rd_start after reset → err_udf=1, rd_valid never asserts; clr_err → err_udf=0 the next cycle.
4. Drain bank 0 while filling bank 1, timed so commit and release land in the same cycle → bank_cnt stays 1; wrap-around bases are correct over 6 frames.
5. wr_valid gapped (1 cycle on, 2 off) → frame commits only after the 4th valid; data is intact.
6. rst asserted after 2 words of a frame → all outputs 0 next cycle; a following full frame reads back correctly from bank 0.
